vote_ctrl7: RTL and testbench

VOTE_CTRL7 -- requirements
Module: vote_ctrl7

---
 rtl/vote_pkg.sv | 21 ++
 rtl/vote_majority7.sv | 14 +
 rtl/vote_ctrl7.sv | 101 ++++++++++
 tb/tb_vote_ctrl7.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the seven-voter vote controller.
// The popcount helper is shared by the controller and the majority block.
package vote_pkg;

  localparam int NVOTERS  = 7;
  localparam int MAJORITY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTE   = 2'd1,
    ST_RESULT = 2'd2
  } vote_state_e;

  function automatic logic [2:0] popcount7(input logic [NVOTERS-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NVOTERS; i++) c = c + {2'b00, m[i]};
    return c;
  endfunction

endpackage

// File: rtl/vote_majority7.sv
// Combinational majority verdict over a 7-bit yes mask.
module vote_majority7
  import vote_pkg::*;
(
  input  logic [NVOTERS-1:0] mask,
  output logic               verdict
);

  logic [2:0] cnt;

  assign cnt     = popcount7(mask);
  assign verdict = (int'(cnt) >= MAJORITY);

endmodule

// File: rtl/vote_ctrl7.sv
// Seven-voter session controller: IDLE -> VOTE -> RESULT with a timed window.
// All outputs are registered; state_dbg mirrors the state register.
module vote_ctrl7
  import vote_pkg::*;
#(
  parameter int WINDOW = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NVOTERS-1:0] yes,
  input  logic [NVOTERS-1:0] no,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         yes_cnt,
  output logic [NVOTERS-1:0] voted,
  output logic [15:0]        time_left,
  output vote_state_e        state_dbg
);

  localparam logic [15:0] LOAD = 16'(WINDOW - 1);

  vote_state_e        state;
  logic [NVOTERS-1:0] yes_mask;
  logic [NVOTERS-1:0] accept;
  logic [NVOTERS-1:0] nxt_voted;
  logic [NVOTERS-1:0] nxt_mask;
  logic               close;
  logic               verdict;

  // A vote counts only from a voter not yet recorded, with exactly one of yes/no.
  always_comb begin
    accept    = ~voted & (yes ^ no);
    nxt_voted = voted | accept;
    nxt_mask  = yes_mask | (accept & yes);
    close     = (time_left == 16'd0) || (&nxt_voted);
  end

  vote_majority7 u_majority (
    .mask    (nxt_mask),
    .verdict (verdict)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      yes_cnt   <= '0;
      voted     <= '0;
      yes_mask  <= '0;
      time_left <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      yes_cnt   <= '0;
      voted     <= '0;
      yes_mask  <= '0;
      time_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_RESULT: begin
          if (start) begin
            state     <= ST_VOTE;
            busy      <= 1'b1;
            pass      <= 1'b0;
            yes_cnt   <= '0;
            voted     <= '0;
            yes_mask  <= '0;
            time_left <= LOAD;
          end
        end
        ST_VOTE: begin
          voted    <= nxt_voted;
          yes_mask <= nxt_mask;
          yes_cnt  <= popcount7(nxt_mask);
          // Closing at time_left==0 means the decrement never has to saturate.
          if (close) begin
            state     <= ST_RESULT;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= verdict;
            time_left <= '0;
          end else begin
            time_left <= time_left - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_ctrl7.sv
// Directed bench for vote_ctrl7 with a per-voter session model checked every cycle.
module tb_vote_ctrl7;
  import vote_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  yes = '0;
  logic [6:0]  no = '0;

  logic        busy, done, pass;
  logic [2:0]  yes_cnt;
  logic [6:0]  voted;
  logic [15:0] time_left;
  vote_state_e state_dbg;

  logic        w1_busy, w1_done, w1_pass;
  logic [2:0]  w1_yes_cnt;
  logic [6:0]  w1_voted;
  logic [15:0] w1_time_left;
  vote_state_e w1_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  vote_ctrl7 #(.WINDOW(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .yes(yes), .no(no),
    .busy(busy), .done(done), .pass(pass), .yes_cnt(yes_cnt), .voted(voted),
    .time_left(time_left), .state_dbg(state_dbg)
  );

  vote_ctrl7 #(.WINDOW(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .yes(yes), .no(no),
    .busy(w1_busy), .done(w1_done), .pass(w1_pass), .yes_cnt(w1_yes_cnt), .voted(w1_voted),
    .time_left(w1_time_left), .state_dbg(w1_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: phase 0 idle, 1 voting, 2 result; m_vote[i] 0 none, 1 yes, 2 no
  int m_phase = 0;
  int m_vote[7] = '{default: 0};
  int m_left = 0;
  bit m_done = 1'b0;

  task automatic model_clear();
    m_phase = 0;
    m_left  = 0;
    m_done  = 1'b0;
    for (int i = 0; i < 7; i++) m_vote[i] = 0;
  endtask

  function automatic int m_yes_count();
    int c = 0;
    for (int i = 0; i < 7; i++) if (m_vote[i] == 1) c++;
    return c;
  endfunction

  function automatic logic [6:0] m_voted_mask();
    logic [6:0] m = '0;
    for (int i = 0; i < 7; i++) m[i] = (m_vote[i] != 0);
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) begin
      model_clear();
    end else begin
      m_done = 1'b0;
      if (m_phase == 1) begin
        for (int i = 0; i < 7; i++)
          if (m_vote[i] == 0 && yes[i] != no[i]) m_vote[i] = yes[i] ? 1 : 2;
        if (m_left == 0 || m_voted_mask() == 7'h7F) begin
          m_phase = 2;
          m_done  = 1'b1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (start) begin
        m_phase = 1;
        m_left  = W - 1;
        for (int i = 0; i < 7; i++) m_vote[i] = 0;
      end
    end
  end

  // scoreboard helper
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 16'(busy), 16'(m_phase == 1));
      check("done", 16'(done), 16'(m_done));
      check("pass", 16'(pass), 16'(m_phase == 2 && m_yes_count() >= 4));
      check("yes_cnt", 16'(yes_cnt), 16'(m_yes_count()));
      check("voted", 16'(voted), 16'(m_voted_mask()));
      check("time_left", time_left, (m_phase == 1) ? 16'(m_left) : 16'd0);
      check("state", 16'(state_dbg),
            16'((m_phase == 0) ? ST_IDLE : (m_phase == 1) ? ST_VOTE : ST_RESULT));
    end
  end

  // driver: apply one cycle of inputs, return just after the rising edge
  task automatic step(input logic s, input logic a, input logic [6:0] y, input logic [6:0] n);
    @(negedge clk);
    start = s;
    abort = a;
    yes   = y;
    no    = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_voted", 16'(voted), 16'd0);
    check("rst_time_left", time_left, 16'd0);
    check("rst_state", 16'(state_dbg), 16'(ST_IDLE));
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // timeout close with four yes votes; WINDOW=1 instance closes after one cycle
    step(1'b1, 1'b0, 7'h00, 7'h00);
    check("t1_busy", 16'(busy), 16'd1);
    check("t1_tl_load", time_left, 16'd7);
    check("w1_busy", 16'(w1_busy), 16'd1);
    check("w1_tl", w1_time_left, 16'd0);
    step(1'b0, 1'b0, 7'h01, 7'h00);
    check("w1_done", 16'(w1_done), 16'd1);
    check("w1_yes_cnt", 16'(w1_yes_cnt), 16'd1);
    check("w1_busy_off", 16'(w1_busy), 16'd0);
    step(1'b0, 1'b0, 7'h02, 7'h00);
    step(1'b0, 1'b0, 7'h04, 7'h00);
    step(1'b0, 1'b0, 7'h08, 7'h00);
    check("t1_yes_cnt_live", 16'(yes_cnt), 16'd4);
    check("t1_tl_mid", time_left, 16'd3);
    repeat (3) step(1'b0, 1'b0, 7'h00, 7'h00);
    check("t1_tl_zero", time_left, 16'd0);
    check("t1_still_busy", 16'(busy), 16'd1);
    check("t1_no_done_yet", 16'(done), 16'd0);
    step(1'b0, 1'b0, 7'h00, 7'h00);
    check("t1_done", 16'(done), 16'd1);
    check("t1_pass", 16'(pass), 16'd1);
    check("t1_yes_cnt", 16'(yes_cnt), 16'd4);
    step(1'b0, 1'b0, 7'h00, 7'h00);
    check("t1_done_pulse", 16'(done), 16'd0);
    check("t1_pass_hold", 16'(pass), 16'd1);

    // start from RESULT, then all seven vote for early close
    step(1'b1, 1'b0, 7'h00, 7'h00);
    check("t2_busy", 16'(busy), 16'd1);
    check("t2_tl_load", time_left, 16'd7);
    check("t2_voted_clr", 16'(voted), 16'd0);
    check("t2_pass_clr", 16'(pass), 16'd0);
    step(1'b0, 1'b0, 7'h07, 7'h00);
    step(1'b0, 1'b0, 7'h00, 7'h08);
    step(1'b0, 1'b0, 7'h00, 7'h30);
    step(1'b0, 1'b0, 7'h00, 7'h40);
    check("t2_done", 16'(done), 16'd1);
    check("t2_pass", 16'(pass), 16'd0);
    check("t2_yes_cnt", 16'(yes_cnt), 16'd3);
    check("t2_voted", 16'(voted), 16'h7F);
    step(1'b0, 1'b0, 7'h00, 7'h00);
    check("t2_voted_hold", 16'(voted), 16'h7F);

    // conflicting yes+no ignored, first accepted vote final
    step(1'b1, 1'b0, 7'h00, 7'h00);
    step(1'b0, 1'b0, 7'h04, 7'h04);
    check("t3_conflict", 16'(voted), 16'h00);
    step(1'b0, 1'b0, 7'h00, 7'h04);
    check("t3_no_taken", 16'(voted), 16'h04);
    step(1'b0, 1'b0, 7'h04, 7'h00);
    check("t3_yes_ignored", 16'(yes_cnt), 16'd0);
    step(1'b0, 1'b0, 7'h0B, 7'h00);
    check("t3_yes_cnt3", 16'(yes_cnt), 16'd3);

    // abort beats start
    step(1'b1, 1'b1, 7'h00, 7'h00);
    check("t4_busy", 16'(busy), 16'd0);
    check("t4_yes_cnt", 16'(yes_cnt), 16'd0);
    check("t4_voted", 16'(voted), 16'd0);
    check("t4_state", 16'(state_dbg), 16'(ST_IDLE));
    step(1'b0, 1'b0, 7'h7F, 7'h00);
    check("t4_idle_ignore", 16'(voted), 16'd0);

    // asynchronous reset mid-session
    step(1'b1, 1'b0, 7'h00, 7'h00);
    step(1'b0, 1'b0, 7'h01, 7'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 16'(busy), 16'd0);
    check("t5_voted", 16'(voted), 16'd0);
    check("t5_yes_cnt", 16'(yes_cnt), 16'd0);
    check("t5_tl", time_left, 16'd0);
    yes = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 7'h00, 7'h00);
    check("t5_reopen_busy", 16'(busy), 16'd1);
    check("t5_reopen_tl", time_left, 16'd7);
    check("t5_reopen_voted", 16'(voted), 16'd0);

    // mixed voting traffic, checked by the model
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
           7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)),
           7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)));
    end
    step(1'b0, 1'b0, 7'h00, 7'h00);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
